// File: rtl/memory_write_buffer_pkg.sv
// Shared types for the posted-write buffer: FSM encoding, default depth and the entry layout.
package memory_write_buffer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam int DEFAULT_DEPTH = 4;
    localparam int ADDR_W        = 30;
    localparam int BE_W          = 4;
    localparam int DATA_W        = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/memory_write_buffer_fifo.sv
// Entry FIFO with two same-cycle push ports, one pop and a per-slot dword compare.
// Zero-latency head; caller must not push past free space or pop when empty.
module memory_write_buffer_fifo
    import memory_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push0,
    input  entry_t            push0_dat,
    input  logic              push1,
    input  entry_t            push1_dat,
    input  logic              pop,
    output entry_t            head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] match_addr,
    output logic [DEPTH-1:0]  addr_match
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_1;
    logic [1:0]    n_push;

    assign wr_ptr_1 = wr_ptr + AW'(1);
    assign n_push   = {1'b0, push0} + {1'b0, push1};
    assign head     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Second entry lands right behind the first; a lone push1 takes the first free slot.
    always_ff @(posedge clk) begin
        if (push0)
            mem[wr_ptr] <= push0_dat;
        if (push1)
            mem[push0 ? wr_ptr_1 : wr_ptr] <= push1_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        addr_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_match[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count) &&
                            (mem[i].addr == match_addr);
        end
    end

endmodule

// File: rtl/memory_write_buffer.sv
// Posted write buffer: splits byte writes into dword entries, acks one cycle after accept.
// Bus side issues head whenever non-empty; requests stall while fewer than two slots are free.
module memory_write_buffer
    import memory_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrbuf_do,
    output logic        wrbuf_done,
    input  logic [31:0] wrbuf_address,
    input  logic [2:0]  wrbuf_length,
    input  logic [31:0] wrbuf_data,
    output logic        mem_write,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] rdcheck_address,
    output logic        rdcheck_hit,
    output logic        empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state, state_nxt;
    logic            accept;
    logic [1:0]      a;
    logic [2:0]      len_eff;
    logic [7:0]      mask8;
    logic [63:0]     data64;
    entry_t          e0, e1, head;
    logic            fifo_full;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] addr_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (wrbuf_do && (count <= CW'(DEPTH - 2)) && !fifo_full) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wrbuf_done = (state == ACK);

    // A write crossing a dword boundary spills its upper lanes into mask8[7:4]/data64[63:32].
    assign a       = wrbuf_address[1:0];
    assign len_eff = (wrbuf_length > 3'd4) ? 3'd4 : wrbuf_length;
    assign mask8   = ((8'd1 << len_eff) - 8'd1) << a;
    assign data64  = {32'd0, wrbuf_data} << {a, 3'b000};

    assign e0 = '{addr: wrbuf_address[31:2],         be: mask8[3:0], data: data64[31:0]};
    assign e1 = '{addr: wrbuf_address[31:2] + 30'd1, be: mask8[7:4], data: data64[63:32]};

    memory_write_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (accept && (mask8[3:0] != 4'd0)),
        .push0_dat  (e0),
        .push1      (accept && (mask8[7:4] != 4'd0)),
        .push1_dat  (e1),
        .pop        (mem_write && !mem_waitrequest),
        .head       (head),
        .full       (fifo_full),
        .empty      (empty),
        .count      (count),
        .match_addr (rdcheck_address[31:2]),
        .addr_match (addr_match)
    );

    assign mem_write      = !empty;
    assign mem_address    = head.addr;
    assign mem_byteenable = head.be;
    assign mem_writedata  = head.data;
    assign rdcheck_hit    = |addr_match;

endmodule

// File: tb/tb_memory_write_buffer.sv
// Directed bench for memory_write_buffer: reset, split/align, stall, wrap, zero length, read check.
module tb_memory_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrbuf_do;
    logic        wrbuf_done;
    logic [31:0] wrbuf_address;
    logic [2:0]  wrbuf_length;
    logic [31:0] wrbuf_data;
    logic        mem_write;
    logic [29:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] rdcheck_address;
    logic        rdcheck_hit;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    logic [29:0] cap_addr [16];
    logic [3:0]  cap_be   [16];
    logic [31:0] cap_data [16];
    int          cap_n;

    always #5 clk = ~clk;

    memory_write_buffer #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wrbuf_do        (wrbuf_do),
        .wrbuf_done      (wrbuf_done),
        .wrbuf_address   (wrbuf_address),
        .wrbuf_length    (wrbuf_length),
        .wrbuf_data      (wrbuf_data),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .rdcheck_address (rdcheck_address),
        .rdcheck_hit     (rdcheck_hit),
        .empty           (empty)
    );

    // All tasks start and end just after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [2:0] len,
                            input logic [31:0] data, output int lat);
        wrbuf_address = addr;
        wrbuf_length  = len;
        wrbuf_data    = data;
        wrbuf_do      = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (wrbuf_done) break;
        end
        wrbuf_do = 1'b0;
    endtask

    task automatic drain(input int ncyc);
        mem_waitrequest = 1'b0;
        cap_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (mem_write && cap_n < 16) begin
                cap_addr[cap_n] = mem_address;
                cap_be[cap_n]   = mem_byteenable;
                cap_data[cap_n] = mem_writedata;
                cap_n++;
            end
            @(posedge clk); #1;
        end
        mem_waitrequest = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks += 4;
        if (wrbuf_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", wrbuf_done); end
        if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (rdcheck_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", rdcheck_hit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_aligned;
        int lat;
        do_write(32'h0000_1000, 3'd4, 32'h4433_2211, lat);
        checks += 5;
        if (lat !== 1) begin failures++; $display("FAIL aligned_latency got=%0d exp=1", lat); end
        if (mem_write !== 1'b1) begin failures++; $display("FAIL aligned_mem_write got=%b exp=1", mem_write); end
        if (mem_address !== 30'h400) begin failures++; $display("FAIL aligned_addr got=%h exp=400", mem_address); end
        if (mem_byteenable !== 4'hF) begin failures++; $display("FAIL aligned_be got=%h exp=f", mem_byteenable); end
        if (mem_writedata !== 32'h4433_2211) begin failures++; $display("FAIL aligned_data got=%h exp=44332211", mem_writedata); end
        drain(6);
        checks += 2;
        if (cap_n !== 1) begin failures++; $display("FAIL aligned_count got=%0d exp=1", cap_n); end
        if (empty !== 1'b1) begin failures++; $display("FAIL aligned_empty_after got=%b exp=1", empty); end
    endtask

    task automatic test_split;
        int lat;
        do_write(32'h0000_1003, 3'd2, 32'h0000_BBAA, lat);
        drain(6);
        checks += 7;
        if (cap_n !== 2) begin failures++; $display("FAIL split_count got=%0d exp=2", cap_n); end
        if (cap_addr[0] !== 30'h400) begin failures++; $display("FAIL split_addr0 got=%h exp=400", cap_addr[0]); end
        if (cap_be[0] !== 4'h8) begin failures++; $display("FAIL split_be0 got=%h exp=8", cap_be[0]); end
        if (cap_data[0] !== 32'hAA00_0000) begin failures++; $display("FAIL split_data0 got=%h exp=aa000000", cap_data[0]); end
        if (cap_addr[1] !== 30'h401) begin failures++; $display("FAIL split_addr1 got=%h exp=401", cap_addr[1]); end
        if (cap_be[1] !== 4'h1) begin failures++; $display("FAIL split_be1 got=%h exp=1", cap_be[1]); end
        if (cap_data[1] !== 32'h0000_00BB) begin failures++; $display("FAIL split_data1 got=%h exp=000000bb", cap_data[1]); end
    endtask

    task automatic test_back_to_back;
        int lat_a, lat_b, lat_c;
        logic        saw_done;
        logic [29:0] ea [5];
        logic [3:0]  eb [5];
        logic [31:0] ed [5];
        ea = '{30'hC00, 30'hC01, 30'hC01, 30'hC02, 30'hC02};
        eb = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h6};
        ed = '{32'hCCBB_AA00, 32'h0000_00DD, 32'h3322_1100, 32'h0000_0044, 32'h0066_5500};
        mem_waitrequest = 1'b1;
        do_write(32'h0000_3001, 3'd4, 32'hDDCC_BBAA, lat_a);
        do_write(32'h0000_3005, 3'd4, 32'h4433_2211, lat_b);
        saw_done = 1'b0;
        fork
            do_write(32'h0000_3009, 3'd2, 32'h0000_6655, lat_c);
            begin
                repeat (5) begin
                    @(posedge clk); #1;
                    if (wrbuf_done) saw_done = 1'b1;
                end
                drain(16);
            end
        join
        checks += 3;
        if (lat_b !== 2) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=2", lat_b); end
        if (saw_done !== 1'b0) begin failures++; $display("FAIL b2b_done_while_full got=%b exp=0", saw_done); end
        if (lat_c !== 8) begin failures++; $display("FAIL b2b_third_latency got=%0d exp=8", lat_c); end
        checks++;
        if (cap_n !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", cap_n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_addr[i] !== ea[i] || cap_be[i] !== eb[i] || cap_data[i] !== ed[i]) begin
                failures++;
                $display("FAIL b2b_entry%0d got=%h/%h/%h exp=%h/%h/%h", i,
                         cap_addr[i], cap_be[i], cap_data[i], ea[i], eb[i], ed[i]);
            end
        end
    endtask

    task automatic test_wrap;
        int lat;
        do_write(32'hFFFF_FFFE, 3'd4, 32'h4433_2211, lat);
        drain(6);
        checks += 3;
        if (cap_n !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", cap_n); end
        if (cap_addr[0] !== 30'h3FFF_FFFF || cap_be[0] !== 4'hC || cap_data[0] !== 32'h2211_0000) begin
            failures++;
            $display("FAIL wrap_entry0 got=%h/%h/%h exp=3fffffff/c/22110000", cap_addr[0], cap_be[0], cap_data[0]);
        end
        if (cap_addr[1] !== 30'h0 || cap_be[1] !== 4'h3 || cap_data[1] !== 32'h0000_4433) begin
            failures++;
            $display("FAIL wrap_entry1 got=%h/%h/%h exp=00000000/3/00004433", cap_addr[1], cap_be[1], cap_data[1]);
        end
    endtask

    task automatic test_zero_len;
        int lat;
        do_write(32'h0000_5000, 3'd0, 32'hFFFF_FFFF, lat);
        checks += 3;
        if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        if (empty !== 1'b1) begin failures++; $display("FAIL zero_empty got=%b exp=1", empty); end
        if (mem_write !== 1'b0) begin failures++; $display("FAIL zero_mem_write got=%b exp=0", mem_write); end
        drain(4);
        checks++;
        if (cap_n !== 0) begin failures++; $display("FAIL zero_bus_writes got=%0d exp=0", cap_n); end
    endtask

    task automatic test_rdcheck_and_reset;
        int lat;
        mem_waitrequest = 1'b1;
        do_write(32'h0000_2004, 3'd4, 32'h1234_5678, lat);
        rdcheck_address = 32'h0000_2007;
        #1;
        checks++;
        if (rdcheck_hit !== 1'b1) begin failures++; $display("FAIL rd_hit_2007 got=%b exp=1", rdcheck_hit); end
        rdcheck_address = 32'h0000_2008;
        #1;
        checks++;
        if (rdcheck_hit !== 1'b0) begin failures++; $display("FAIL rd_hit_2008 got=%b exp=0", rdcheck_hit); end
        rdcheck_address = 32'h0000_2004;
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
        if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        if (rdcheck_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", rdcheck_hit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain(5);
        checks++;
        if (cap_n !== 0) begin failures++; $display("FAIL rst_no_bus_write got=%0d exp=0", cap_n); end
    endtask

    initial begin
        wrbuf_do        = 1'b0;
        wrbuf_address   = '0;
        wrbuf_length    = '0;
        wrbuf_data      = '0;
        mem_waitrequest = 1'b1;
        rdcheck_address = '0;
        test_reset();
        test_aligned();
        test_split();
        test_back_to_back();
        test_wrap();
        test_zero_len();
        test_rdcheck_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
